// File: rtl/arcade_led_driver_pkg.sv
// Purpose: shared command/state encodings and heartbeat constants for the arcade LED driver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package led_pkg;

    // Encoding of the cmd_mode port.
    typedef enum logic [1:0] {
        MODE_OFF       = 2'd0,
        MODE_SOLID     = 2'd1,
        MODE_BLINK     = 2'd2,
        MODE_HEARTBEAT = 2'd3
    } led_mode_t;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_SOLID     = 3'd1,
        ST_BLINK_INF = 3'd2,
        ST_BLINK_N   = 3'd3,
        ST_HEARTBEAT = 3'd4
    } led_state_t;

    // Heartbeat: lit for the first phase of every four-phase period.
    localparam int HEARTBEAT_ON_PHASES = 1;
    localparam int HEARTBEAT_PERIOD    = 4;

endpackage

// File: rtl/arcade_led_driver_phase_timer.sv
// Purpose: pattern-phase prescaler; phase_tick marks the last cycle of each phase.
// Latency: phase_tick decodes the counter register; restart clears it on the next edge.
// Backpressure: none; free-running unless restarted.
//
// Ports: clock, reset (async, active-high), restart (zero the count),
//        phase_tick (high while the count sits at TICKS_PER_PHASE-1).
module phase_timer #(
    parameter int TICKS_PER_PHASE = 12_500_000
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic phase_tick
);

    localparam int                CNT_W = $clog2(TICKS_PER_PHASE);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TICKS_PER_PHASE - 1);

    logic [CNT_W-1:0] cnt_q;

    assign phase_tick = (cnt_q == LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (restart || phase_tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/arcade_led_driver.sv
// Purpose: drives the arcade button LED pin with OFF/SOLID/BLINK/HEARTBEAT patterns from game-logic commands.
// Latency: pin reflects an accepted command from the cycle after the accept edge (pin is a flop).
// Backpressure: cmd_ready drops only while a finite BLINK sequence runs; all other patterns are preemptable.
//
// Ports: clock, reset (async, active-high); cmd_valid/cmd_ready handshake with cmd_mode,
//        cmd_count (BLINK pairs, 0 = forever) and pwm_duty; busy/done status; ARCADE_LED pin.
// Build option: define ARCADE_LED_PWM_EN to gate the lit level with a PWM_BITS-wide duty cycle.
module arcade_led_driver
    import led_pkg::*;
#(
    parameter int TICKS_PER_PHASE = 12_500_000,
    parameter int LED_ACTIVE_LOW  = 0,
    parameter int PWM_BITS        = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_mode,
    input  logic [3:0]          cmd_count,
    input  logic [PWM_BITS-1:0] pwm_duty,
    output logic                busy,
    output logic                done,
    output logic                ARCADE_LED
);

    localparam logic LED_IDLE = (LED_ACTIVE_LOW != 0);

    led_state_t state_q, state_n;
    logic [1:0] idx_q, idx_n;       // phase index within the pattern
    logic [3:0] pair_q, pair_n;     // completed OFF phases in BLINK_N
    logic [3:0] count_q, count_n;   // captured pair target
    logic       done_q, done_n;
    logic       led_q;
    logic       lit_n, gated_n;
    logic       accept, phase_tick;

    assign cmd_ready  = (state_q != ST_BLINK_N);
    assign busy       = (state_q == ST_BLINK_N);
    assign done       = done_q;
    assign ARCADE_LED = led_q;
    assign accept     = cmd_valid && cmd_ready;

    phase_timer #(
        .TICKS_PER_PHASE (TICKS_PER_PHASE)
    ) u_phase_timer (
        .clock      (clock),
        .reset      (reset),
        .restart    (accept),
        .phase_tick (phase_tick)
    );

    // Accept always wins over the phase tick: a new command restarts the pattern.
    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        pair_n  = pair_q;
        count_n = count_q;
        done_n  = 1'b0;
        if (accept) begin
            idx_n   = '0;
            pair_n  = '0;
            count_n = cmd_count;
            case (led_mode_t'(cmd_mode))
                MODE_SOLID:     state_n = ST_SOLID;
                MODE_BLINK:     state_n = (cmd_count == 4'd0) ? ST_BLINK_INF : ST_BLINK_N;
                MODE_HEARTBEAT: state_n = ST_HEARTBEAT;
                default:        state_n = ST_OFF;
            endcase
        end else if (phase_tick) begin
            case (state_q)
                ST_BLINK_INF, ST_HEARTBEAT: begin
                    idx_n = idx_q + 1'b1;
                end
                ST_BLINK_N: begin
                    idx_n = idx_q + 1'b1;
                    // Odd index is an OFF phase; its end closes one on/off pair.
                    if (idx_q[0]) begin
                        if (pair_q == count_q - 4'd1) begin
                            done_n  = 1'b1;
                            state_n = ST_OFF;
                            idx_n   = '0;
                            pair_n  = '0;
                        end else begin
                            pair_n = pair_q + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Lit level is decoded from next-state so the registered pin lines up with the accept edge.
    always_comb begin
        lit_n = 1'b0;
        case (state_n)
            ST_SOLID:                 lit_n = 1'b1;
            ST_BLINK_INF, ST_BLINK_N: lit_n = !idx_n[0];
            ST_HEARTBEAT:             lit_n = (idx_n < 2'(HEARTBEAT_ON_PHASES));
            default:                  lit_n = 1'b0;
        endcase
    end

`ifdef ARCADE_LED_PWM_EN
    logic [PWM_BITS-1:0] pwm_cnt_q, duty_q, duty_n;

    assign duty_n  = accept ? pwm_duty : duty_q;
    assign gated_n = lit_n && (pwm_cnt_q < duty_n);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pwm_cnt_q <= '0;
            duty_q    <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            duty_q    <= duty_n;
        end
    end
`else
    logic unused_pwm_duty;
    assign unused_pwm_duty = ^pwm_duty;
    assign gated_n         = lit_n;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_OFF;
            idx_q   <= '0;
            pair_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            led_q   <= LED_IDLE;
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
            pair_q  <= pair_n;
            count_q <= count_n;
            done_q  <= done_n;
            led_q   <= gated_n ^ LED_IDLE;
        end
    end

endmodule

// File: tb/tb_arcade_led_driver.sv
// Purpose: self-checking bench for arcade_led_driver against an elapsed-time pattern model.
// Latency: n/a.
// Backpressure: n/a.
module tb_arcade_led_driver;

    localparam int T  = 4;
    localparam int PB = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_mode;
    logic [3:0]    cmd_count;
    logic [PB-1:0] pwm_duty;
    logic          busy;
    logic          done;
    logic          ARCADE_LED;

    int checks = 0;
    int errors = 0;

    arcade_led_driver #(
        .TICKS_PER_PHASE (T),
        .LED_ACTIVE_LOW  (0),
        .PWM_BITS        (PB)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_count  (cmd_count),
        .pwm_duty   (pwm_duty),
        .busy       (busy),
        .done       (done),
        .ARCADE_LED (ARCADE_LED)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: the active command plus cycles elapsed since it was accepted.
    int m_mode, m_cnt, m_k, m_duty, m_pwm;
    bit m_gate;

    function automatic int total_cycles();
        return 2 * m_cnt * T;
    endfunction

    function automatic bit finite_blink();
        return (m_mode == 2) && (m_cnt != 0);
    endfunction

    function automatic bit exp_busy();
        return finite_blink() && (m_k < total_cycles());
    endfunction

    function automatic bit exp_done();
        return finite_blink() && (m_k == total_cycles());
    endfunction

    function automatic bit exp_led();
        bit lit;
        int phase;
        phase = m_k / T;
        case (m_mode)
            1:       lit = 1'b1;
            2:       lit = (phase % 2 == 0) && (m_cnt == 0 || m_k < total_cycles());
            3:       lit = (phase % 4 == 0);
            default: lit = 1'b0;
        endcase
`ifdef ARCADE_LED_PWM_EN
        lit = lit && m_gate;
`endif
        return lit;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_mode = 0; m_cnt = 0; m_k = 0; m_duty = 0; m_pwm = 0; m_gate = 1'b0;
        end else begin
            if (cmd_valid && !exp_busy()) begin
                m_mode = int'(cmd_mode);
                m_cnt  = int'(cmd_count);
                m_duty = int'(pwm_duty);
                m_k    = 0;
            end else if (m_k < 100000) begin
                m_k++;
            end
            m_gate = (m_pwm < m_duty);
            m_pwm  = (m_pwm + 1) % (1 << PB);
        end
    end

    task automatic check_outputs();
        check_eq("led",   32'(ARCADE_LED), 32'(exp_led()));
        check_eq("ready", 32'(cmd_ready),  32'(!exp_busy()));
        check_eq("busy",  32'(busy),       32'(exp_busy()));
        check_eq("done",  32'(done),       32'(exp_done()));
    endtask

    task automatic cmd(input int mode, input int count, input int duty);
        cmd_valid = 1'b1;
        cmd_mode  = 2'(mode);
        cmd_count = 4'(count);
        pwm_duty  = PB'(duty);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clock);
            check_outputs();
            cmd_valid = 1'b0;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_led"},   32'(ARCADE_LED), 32'd0);
        check_eq({tag, "_ready"}, 32'(cmd_ready),  32'd1);
        check_eq({tag, "_busy"},  32'(busy),       32'd0);
        check_eq({tag, "_done"},  32'(done),       32'd0);
    endtask

    int lit_cnt;
    int done_cnt;

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_mode  = 2'd0;
        cmd_count = 4'd0;
        pwm_duty  = '0;
        #1;
        check_reset_values("por");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        run(2);

        // SOLID held for 100 cycles.
        cmd(1, 0, 15);
        run(100);

        // Finite blink, two pairs, and its trailing done pulse.
        cmd(2, 2, 15);
        done_cnt = 0;
        repeat (20) begin
            run(1);
            done_cnt += int'(done);
        end
        check_eq("blink2_done_pulses", 32'(done_cnt), 32'd1);

        // Infinite blink preempted by OFF during the ON phase.
        cmd(2, 0, 15);
        run(2);
        cmd(0, 0, 15);
        run(1);
        check_eq("preempt_led_off", 32'(ARCADE_LED), 32'd0);
        run(12);

        // Heartbeat over three periods.
        cmd(3, 0, 15);
        run(48);

        // New SOLID accepted in the done cycle.
        cmd(2, 1, 15);
        run(9);
        check_eq("coincide_done", 32'(done), 32'd1);
        cmd(1, 0, 15);
        run(1);
        check_eq("coincide_led", 32'(ARCADE_LED), 32'd1);
        run(3);

        // Reset mid-sequence takes effect without a clock edge.
        cmd(2, 3, 15);
        run(5);
        check_eq("pre_reset_busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("midrst");
        @(negedge clock);
        reset = 1'b0;
        run(3);

`ifdef ARCADE_LED_PWM_EN
        cmd(1, 0, 4);
        run(1);
        lit_cnt = 0;
        repeat (32) begin
            run(1);
            lit_cnt += int'(ARCADE_LED);
        end
        check_eq("pwm_duty4_lit", 32'(lit_cnt), 32'd8);
        cmd(1, 0, 0);
        run(1);
        lit_cnt = 0;
        repeat (32) begin
            run(1);
            lit_cnt += int'(ARCADE_LED);
        end
        check_eq("pwm_duty0_lit", 32'(lit_cnt), 32'd0);
`endif

        // Random command traffic.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            check_outputs();
            if ($urandom_range(0, 11) == 0) begin
                cmd_valid = 1'b1;
                cmd_mode  = 2'($urandom_range(0, 3));
                cmd_count = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3))
                                                        : 4'($urandom_range(0, 15));
                pwm_duty  = PB'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
